calculation_unit_fraction_addsub_pipe: RTL and testbench

Parametrised, pipelined fraction adder/subtractor for the calculation unit. It combines a sorted significand with an aligned, double-width significand and supports both effective addition and effective subtraction. The adder is split across `STAGES` registered carry-chain segments behind valid/ready handshakes, so long fraction paths no longer limit Fmax. It returns the magnitude of the result with carry-out, sign-flip and zero flags, plus a pass-through tag for the issuing operation.

---
 rtl/calculation_unit_fraction_addsub_pipe.sv | 157 +++++++++++++++
 tb/tb_calculation_unit_fraction_addsub_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calculation_unit_fraction_addsub_pipe.sv
// Pipelined significand adder/subtractor: the W-bit carry chain is cut into STAGES
// registered segments behind valid/ready handshakes; the last stage negates on borrow.
module calculation_unit_fraction_addsub_pipe #(
   parameter  int FRAC_WIDTH = 24,
   parameter  int STAGES     = 2,
   parameter  int TAG_WIDTH  = 4,
   localparam int W          = 2*FRAC_WIDTH+1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 op_sub,
   input  logic [FRAC_WIDTH-1:0] sorted_fraction_a,
   input  logic [W-1:0]         aligned_fraction_b,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         fraction_result,
   output logic                 carry_out,
   output logic                 sign_flip,
   output logic                 result_zero,
   output logic [TAG_WIDTH-1:0] out_tag
);

   localparam int SEG = (W + STAGES - 1) / STAGES;

   // st_*[k] is the operand bundle entering stage k (stage 0 is fed by the ports)
   logic [W-1:0]         st_a   [STAGES];
   logic [W-1:0]         st_b   [STAGES];
   logic [W-1:0]         st_sum [STAGES];
   logic [TAG_WIDTH-1:0] st_tag [STAGES];
   logic [STAGES-1:0]    st_c;
   logic [STAGES-1:0]    st_sub;
   logic [STAGES-1:0]    stage_v;
   logic [STAGES:0]      v_chain;
   logic [STAGES-1:0]    ld;

   assign st_a[0]   = {1'b0, sorted_fraction_a, {FRAC_WIDTH{1'b0}}};
   assign st_b[0]   = op_sub ? ~aligned_fraction_b : aligned_fraction_b;
   assign st_sum[0] = '0;
   assign st_c[0]   = op_sub;
   assign st_sub[0] = op_sub;
   assign st_tag[0] = in_tag;
   assign v_chain   = {stage_v, in_valid};
   assign in_ready  = ld[0];

   // Ready chain: a stage loads when empty or when its occupant moves on this cycle.
   always_comb begin
      logic chain;
      ld    = '0;
      chain = out_ready;
      for (int s = STAGES-1; s >= 0; s--) begin
         ld[s] = !stage_v[s] || chain;
         chain = ld[s];
      end
   end

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         localparam int         LO        = (gi*SEG < W) ? gi*SEG : W;
         localparam int         HI        = ((gi+1)*SEG < W) ? (gi+1)*SEG : W;
         localparam logic [W:0] ONE       = {{W{1'b0}}, 1'b1};
         localparam logic [W:0] SEG_MASK  = (ONE << HI) - (ONE << LO);
         localparam logic [W:0] CARRY_BIT = ONE << HI;

         logic [W:0]   seg_t;
         logic [W-1:0] sum_d;
         logic         c_d;
         logic         load;
         logic         v_q;

         always_comb begin
            seg_t = {1'b0, st_a[gi] & SEG_MASK[W-1:0]}
                  + {1'b0, st_b[gi] & SEG_MASK[W-1:0]}
                  + ({{W{1'b0}}, st_c[gi]} << LO);
            sum_d = (st_sum[gi] & ~SEG_MASK[W-1:0]) | (seg_t[W-1:0] & SEG_MASK[W-1:0]);
            c_d   = |(seg_t & CARRY_BIT);
         end

         assign load        = ld[gi] && v_chain[gi];
         assign stage_v[gi] = v_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) v_q <= 1'b0;
            else if (ld[gi]) v_q <= v_chain[gi];
         end

         if (gi < STAGES-1) begin : g_mid
            logic [W-1:0]         a_q, b_q, sum_q;
            logic                 c_q, sub_q;
            logic [TAG_WIDTH-1:0] tag_q;

            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  a_q   <= '0;
                  b_q   <= '0;
                  sum_q <= '0;
                  c_q   <= 1'b0;
                  sub_q <= 1'b0;
                  tag_q <= '0;
               end else if (load) begin
                  a_q   <= st_a[gi];
                  b_q   <= st_b[gi];
                  sum_q <= sum_d;
                  c_q   <= c_d;
                  sub_q <= st_sub[gi];
                  tag_q <= st_tag[gi];
               end
            end

            assign st_a[gi+1]   = a_q;
            assign st_b[gi+1]   = b_q;
            assign st_sum[gi+1] = sum_q;
            assign st_c[gi+1]   = c_q;
            assign st_sub[gi+1] = sub_q;
            assign st_tag[gi+1] = tag_q;
         end else begin : g_last
            logic [W-1:0]         res_d, res_q;
            logic                 co_d, co_q, flip_d, flip_q, zero_d, zero_q;
            logic [TAG_WIDTH-1:0] tag_q;

            // No carry out of a subtract means a borrow: report B-A and flag it.
            always_comb begin
               flip_d = st_sub[gi] && !c_d;
               co_d   = !st_sub[gi] && c_d;
               res_d  = flip_d ? -sum_d : sum_d;
               zero_d = (res_d == '0);
            end

            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  res_q  <= '0;
                  co_q   <= 1'b0;
                  flip_q <= 1'b0;
                  zero_q <= 1'b0;
                  tag_q  <= '0;
               end else if (load) begin
                  res_q  <= res_d;
                  co_q   <= co_d;
                  flip_q <= flip_d;
                  zero_q <= zero_d;
                  tag_q  <= st_tag[gi];
               end
            end

            assign out_valid       = v_q;
            assign fraction_result = res_q;
            assign carry_out       = co_q;
            assign sign_flip       = flip_q;
            assign result_zero     = zero_q;
            assign out_tag         = tag_q;
         end
      end
   endgenerate

endmodule

// File: tb/tb_calculation_unit_fraction_addsub_pipe.sv
// Directed + random bench for the pipelined fraction add/sub, scoreboard-checked.
module tb_calculation_unit_fraction_addsub_pipe;

   localparam int F  = 24;
   localparam int ST = 2;
   localparam int TW = 4;
   localparam int W  = 2*F+1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          op_sub = 1'b0;
   logic [F-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [TW-1:0] in_tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  fraction_result;
   logic          carry_out, sign_flip, result_zero;
   logic [TW-1:0] out_tag;

   calculation_unit_fraction_addsub_pipe #(
      .FRAC_WIDTH(F), .STAGES(ST), .TAG_WIDTH(TW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
      .sorted_fraction_a(a), .aligned_fraction_b(b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .fraction_result(fraction_result), .carry_out(carry_out),
      .sign_flip(sign_flip), .result_zero(result_zero), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]  res;
      logic          co;
      logic          flip;
      logic          zero;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   pops = 0;
   bit   acc_flag = 1'b0;
   bit   use_fixed = 1'b0;
   exp_t fixed_exp;

   // Reference: plain wide arithmetic, magnitude compare for subtract.
   function automatic exp_t model(input logic [F-1:0] fa, input logic [W-1:0] fb,
                                  input logic sub, input logic [TW-1:0] tg);
      exp_t       e;
      logic [W:0] aa, bb, s;
      aa = {2'b00, fa, {F{1'b0}}};
      bb = {1'b0, fb};
      e.tag = tg;
      if (!sub) begin
         s = aa + bb;
         e.res = s[W-1:0];
         e.co = s[W];
         e.flip = 1'b0;
      end else if (aa >= bb) begin
         s = aa - bb;
         e.res = s[W-1:0];
         e.co = 1'b0;
         e.flip = 1'b0;
      end else begin
         s = bb - aa;
         e.res = s[W-1:0];
         e.co = 1'b0;
         e.flip = 1'b1;
      end
      e.zero = (e.res == '0);
      return e;
   endfunction

   function automatic exp_t mk(input logic [W-1:0] r, input logic co, input logic fl,
                               input logic z, input logic [TW-1:0] tg);
      exp_t e;
      e.res = r; e.co = co; e.flip = fl; e.zero = z; e.tag = tg;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", name, obs, expv);
      end
   endtask

   // One cycle: called just after a negedge; books handshakes, then waits for next negedge.
   task automatic tick();
      exp_t obs, e;
      #1;
      acc_flag = in_valid && in_ready;
      if (out_valid && out_ready) begin
         obs = {fraction_result, carry_out, sign_flip, result_zero, out_tag};
         total++;
         assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL unexpected_output: observed tag=%0d res=%h expected no output", out_tag, fraction_result);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (obs === e) else begin
               bad++;
               $error("FAIL result: observed res=%h c=%0b f=%0b z=%0b tag=%0d expected res=%h c=%0b f=%0b z=%0b tag=%0d",
                      obs.res, obs.co, obs.flip, obs.zero, obs.tag, e.res, e.co, e.flip, e.zero, e.tag);
            end
         end
         pops++;
         $display("txn out tag=%0d res=%h carry=%0b flip=%0b zero=%0b",
                  out_tag, fraction_result, carry_out, sign_flip, result_zero);
      end
      if (acc_flag) sb.push_back(use_fixed ? fixed_exp : model(a, b, op_sub, in_tag));
      @(negedge clk);
   endtask

   task automatic send(input logic [F-1:0] fa, input logic [W-1:0] fb, input logic sub,
                       input logic [TW-1:0] tg, input bit fixed, input exp_t fe);
      bit got;
      got = 1'b0;
      a = fa; b = fb; op_sub = sub; in_tag = tg; in_valid = 1'b1;
      use_fixed = fixed; fixed_exp = fe;
      for (int k = 0; k < 200 && !got; k++) begin
         tick();
         got = acc_flag;
      end
      chk("accept_timeout", 64'(got), 64'd1);
      in_valid = 1'b0;
      use_fixed = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid = 1'b0;
      for (int k = 0; k < 200 && sb.size() > 0; k++) tick();
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic rand_op();
      a = F'($urandom());
      case ($urandom_range(0, 3))
         0: b = {1'b0, a, {F{1'b0}}};
         1: b = W'({$urandom(), $urandom()});
         2: b = W'({$urandom(), $urandom()}) >> $urandom_range(0, W-1);
         default: b = '1;
      endcase
      op_sub = 1'($urandom_range(0, 1));
      in_tag = TW'($urandom());
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   lat, tagi, n, seen, naccepted;
      bit   need, have_hold;
      logic [W-1:0] held;
      exp_t none;
      none = '0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(fraction_result), 64'd0);
      chk("rst_flags", 64'({carry_out, sign_flip, result_zero}), 64'd0);
      chk("rst_tag", 64'(out_tag), 64'd0);
      reset_n = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);

      // Directed add with latency measurement
      send(24'h800000, 49'h0800000000000, 1'b0, 4'd1, 1'b1, mk(49'h1000000000000, 1'b0, 1'b0, 1'b0, 4'd1));
      lat = 0;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      chk("latency", 64'(lat), 64'(ST-1));
      drain();

      // Directed overflow and subtracts, back to back
      send(24'hFFFFFF, 49'h1FFFFFFFFFFFF, 1'b0, 4'd2, 1'b1, mk(49'h0FFFFFEFFFFFF, 1'b1, 1'b0, 1'b0, 4'd2));
      send(24'h800000, 49'h0400000000000, 1'b1, 4'd3, 1'b1, mk(49'h0400000000000, 1'b0, 1'b0, 1'b0, 4'd3));
      send(24'h800000, 49'h0C00000000000, 1'b1, 4'd4, 1'b1, mk(49'h0400000000000, 1'b0, 1'b1, 1'b0, 4'd4));
      send(24'h800000, 49'h0800000000000, 1'b1, 4'd5, 1'b1, mk(49'h0, 1'b0, 1'b0, 1'b1, 4'd5));
      drain();

      // Backpressure: out_ready low, offer tags 1..4
      out_ready = 1'b0;
      tagi = 1;
      have_hold = 1'b0;
      held = '0;
      n = pops;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (tagi <= 4) begin rand_op(); in_tag = TW'(tagi); in_valid = 1'b1; end
         tick();
         if (acc_flag) tagi++;
         if (out_valid) begin
            chk("stall_tag", 64'(out_tag), 64'd1);
            if (have_hold) chk("stall_hold", 64'(fraction_result), 64'(held));
            held = fraction_result;
            have_hold = 1'b1;
         end
      end
      chk("stall_accepts", 64'(tagi-1), 64'(ST));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      tick();
      chk("fill_while_drain", 64'(acc_flag), 64'd1);
      if (acc_flag) tagi++;
      for (int k = 0; k < 50 && tagi <= 4; k++) begin
         rand_op(); in_tag = TW'(tagi); in_valid = 1'b1;
         tick();
         if (acc_flag) tagi++;
      end
      drain();
      chk("bp_count", 64'(pops - n), 64'd4);

      // Throughput with constant out_ready
      n = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         rand_op(); in_valid = 1'b1;
         tick();
         if (acc_flag) n++;
      end
      chk("throughput", 64'(n), 64'd50);
      drain();

      // Random streaming with random backpressure
      naccepted = 0;
      need = 1'b1;
      for (int cyc = 0; cyc < 20000 && naccepted < 1000; cyc++) begin
         if (need) begin rand_op(); in_valid = ($urandom_range(0, 9) < 8); end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         if (acc_flag) naccepted++;
         need = acc_flag || !in_valid;
      end
      chk("stream_count", 64'(naccepted), 64'd1000);
      drain();

      // Reset with entries in flight
      out_ready = 1'b0;
      send(24'h123456, 49'h0000000ABCDEF, 1'b0, 4'd7, 1'b0, none);
      send(24'h654321, 49'h0000000FEDCBA, 1'b1, 4'd8, 1'b0, none);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (out_valid) seen++;
      end
      chk("midrst_no_stale", 64'(seen), 64'd0);

      // Pipe works again after reset
      send(24'h800000, 49'h0C00000000000, 1'b1, 4'd9, 1'b1, mk(49'h0400000000000, 1'b0, 1'b1, 1'b0, 4'd9));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
